// File: rtl/ring_decoder.sv
// Ring-counter code decoder: tracks a right-rotating one-hot sequence, locks after
// LOCK_CNT consecutive correct steps, and flags malformed or out-of-order samples.
module ring_decoder #(
   parameter int unsigned N        = 4,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned ERR_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [N-1:0]           ring_in,
   output logic [$clog2(N)-1:0]   idx_out,
   output logic                   idx_valid,
   output logic                   locked,
   output logic                   err_onehot,
   output logic                   err_seq,
   output logic                   wrap_pulse,
   output logic [ERR_W-1:0]       err_count
);

   localparam int unsigned IDX_W  = $clog2(N);
   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [N-1:0]       prev_q;
   logic [N-1:0]       prev_d;
   logic [GOOD_W-1:0]  good_q;
   logic [GOOD_W-1:0]  good_d;
   logic [GOOD_W-1:0]  good_inc;
   logic [IDX_W-1:0]   idx_d;
   logic               idx_valid_d;
   logic               locked_d;
   logic               err_onehot_d;
   logic               err_seq_d;
   logic               wrap_d;
   logic [ERR_W-1:0]   err_count_d;

   logic               is_onehot;
   logic [IDX_W-1:0]   samp_idx;
   logic [N-1:0]       exp_code;
   logic               match;

   // Sample classification against the expected right rotation of prev
   always_comb begin : decode
      is_onehot = $onehot(ring_in);
      samp_idx  = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (ring_in[i]) begin
            samp_idx = IDX_W'(i);
         end
      end
      exp_code = {prev_q[0], prev_q[N-1:1]};
      match    = is_onehot && (ring_in == exp_code);
      good_inc = good_q + GOOD_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      if (in_valid) begin
         if (!is_onehot) begin
            state_d = HUNT;
         end else begin
            case (state_q)
               HUNT:    state_d = VERIFY;
               VERIFY:  if (match && (good_inc == GOOD_W'(LOCK_CNT))) state_d = LOCKED;
               LOCKED:  if (!match) state_d = HUNT;
               default: state_d = HUNT;
            endcase
         end
      end
   end

   always_comb begin : output_logic
      prev_d       = prev_q;
      good_d       = good_q;
      idx_d        = idx_out;
      idx_valid_d  = 1'b0;
      err_onehot_d = 1'b0;
      err_seq_d    = 1'b0;
      wrap_d       = 1'b0;
      if (in_valid) begin
         if (!is_onehot) begin
            err_onehot_d = 1'b1;
            good_d       = '0;
         end else begin
            idx_valid_d = 1'b1;
            idx_d       = samp_idx;
            case (state_q)
               HUNT: begin
                  prev_d = ring_in;
                  good_d = '0;
               end
               VERIFY: begin
                  prev_d = ring_in;
                  if (match) begin
                     good_d = good_inc;
                  end else begin
                     err_seq_d = 1'b1;
                     good_d    = '0;
                  end
               end
               LOCKED: begin
                  if (match) begin
                     prev_d = ring_in;
                     // Only the 0...01 -> 10...0 step of an already locked ring is a wrap
                     wrap_d = (prev_q == N'(1));
                  end else begin
                     err_seq_d = 1'b1;
                  end
               end
               default: begin
                  prev_d = '0;
                  good_d = '0;
               end
            endcase
         end
      end
      err_count_d = err_count;
      if ((err_onehot_d || err_seq_d) && (err_count != {ERR_W{1'b1}})) begin
         err_count_d = err_count + ERR_W'(1);
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin : out_reg
      if (!rst_n) begin
         prev_q     <= '0;
         good_q     <= '0;
         idx_out    <= '0;
         idx_valid  <= 1'b0;
         locked     <= 1'b0;
         err_onehot <= 1'b0;
         err_seq    <= 1'b0;
         wrap_pulse <= 1'b0;
         err_count  <= '0;
      end else begin
         prev_q     <= prev_d;
         good_q     <= good_d;
         idx_out    <= idx_d;
         idx_valid  <= idx_valid_d;
         locked     <= locked_d;
         err_onehot <= err_onehot_d;
         err_seq    <= err_seq_d;
         wrap_pulse <= wrap_d;
         err_count  <= err_count_d;
      end
   end

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 Parameter N, default 4: ring code width, N >= 2.
REQ-002 Parameter LOCK_CNT, default 3: consecutive correct transitions required to lock, >= 1.
REQ-003 Parameter ERR_W, default 8: error counter width.
REQ-004 clk  input  1  the block's one clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  ring_in is a sample this cycle.
REQ-007 ring_in  input  N  ring counter code under decode.
REQ-008 idx_out  output  clog2(N)  bit position of the set bit in the last valid one-hot sample.
REQ-009 idx_valid  output  1  one-cycle pulse; idx_out was updated.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 err_onehot  output  1  one-cycle pulse; a non-one-hot sample was received.
REQ-012 err_seq  output  1  one-cycle pulse; a one-hot sample did not equal the expected next code.
REQ-013 wrap_pulse  output  1  one-cycle pulse; a locked ring wrapped from index 0 to index N-1.
REQ-014 err_count  output  ERR_W  saturating count of err_onehot plus err_seq events.

Function
REQ-015 The block shall decode the ring sequence 1000 -> 0100 -> 0010 -> 0001 -> 1000 (N=4).
- Expected next code = {prev[0], prev[N-1:1]}, a right rotate.
REQ-016 All outputs shall be registered, with a latency of exactly 1 cycle from the sampled edge.
REQ-017 A cycle with in_valid=0 shall change no state, counter or prev value, and shall pulse no output.
REQ-018 A sample is one-hot when exactly one bit of ring_in is set.
- All-zero and multi-bit samples shall be non-one-hot.
REQ-019 The FSM shall have the states HUNT, VERIFY and LOCKED, and shall enter HUNT at reset.
REQ-020 HUNT, valid one-hot sample: store the sample as prev, set good_cnt=0, go to VERIFY.
- Valid non-one-hot sample: stay in HUNT.
REQ-021 VERIFY, valid sample equal to the expected next code: store it as prev and increment good_cnt.
- When good_cnt reaches LOCK_CNT, go to LOCKED.
REQ-022 VERIFY, valid one-hot mismatch: pulse err_seq, store the sample as prev, reset good_cnt to 0, stay in VERIFY.
REQ-023 LOCKED, valid sample equal to the expected next code: store it as prev, stay in LOCKED.
REQ-024 LOCKED, valid one-hot mismatch: pulse err_seq and go to HUNT.
- A repeated, un-rotated code counts as a mismatch.
REQ-025 Any state, valid non-one-hot sample: pulse err_onehot, go to HUNT, leave idx_out unchanged, keep idx_valid low.
REQ-026 Every valid one-hot sample shall update idx_out and pulse idx_valid, in any state.
REQ-027 wrap_pulse shall fire only for an accepted prev=0...01 -> 10...0 transition that occurs while in LOCKED.
- The transition that causes entry into LOCKED shall not fire wrap_pulse.
REQ-028 err_onehot and err_seq shall never assert in the same cycle.
REQ-029 err_count shall increment by 1 per error pulse and shall saturate at all-ones without wrapping.
- err_count shall be cleared only by reset.
REQ-030 good_cnt shall be wide enough to hold LOCK_CNT and shall never wrap.

Reset
REQ-031 On rst_n low, the block shall immediately, without waiting for a clock edge:
- set state=HUNT, prev=0 and good_cnt=0;
- drive idx_out=0, err_count=0, and all pulse outputs and locked to 0.
REQ-032 Reset asserted mid-lock shall drop locked immediately.
- After release, relock shall require a fresh HUNT->VERIFY->LOCKED sequence.
REQ-033 The first rising edge after rst_n goes high shall be processed normally.

Verification
REQ-034 Reset, then valid samples 1000,0100,0010,0001 on back-to-back cycles.
- Response: idx_out 3,2,1,0, each with idx_valid one cycle after its sample.
- Response: locked=1 one cycle after 0001; no error pulses.
REQ-035 Locked at prev=0001, then sample 1000.
- Response: wrap_pulse=1 and idx_out=3 for one cycle; locked stays 1.
REQ-036 Locked at prev=0100, then sample 0100.
- Response: err_seq pulse, err_count 0->1, locked=0 next cycle, state HUNT.
REQ-037 Locked, then sample 0110, followed by 0000.
- Response: err_onehot on both samples, err_count +2, idx_valid stays 0, idx_out unchanged, locked=0.
REQ-038 Locked, then in_valid=0 for 5 cycles, then sample the expected next code.
- Response: no pulses during the gap, locked held, idx_valid on the resumed sample.
REQ-039 ERR_W=2, 5 consecutive valid 0000 samples.
- Response: err_count 1,2,3,3,3, saturating at 3.
- Then assert rst_n low mid-cycle: err_count=0 and locked=0 before the next clk edge.
